// File: rtl/diram_phy_resp_pkg.sv
// Shared types for the DiRAM PHY responder: DFI command encoding, error flag
// positions and the read-pipeline entry carried through the latency line.
package diram_phy_resp_pkg;

  localparam int DFLT_NUM_BANKS = 8;
  localparam int DFLT_COL_W     = 4;
  localparam int PIPE_BANK_W    = $clog2(DFLT_NUM_BANKS);
  localparam int PIPE_COL_W     = DFLT_COL_W;

  typedef enum logic [1:0] {
    ACT = 2'b00,
    RD  = 2'b01,
    WR  = 2'b10,
    PRE = 2'b11
  } cmd_e;

  localparam int ERR_CLOSED  = 0;
  localparam int ERR_OPEN    = 1;
  localparam int ERR_SPACING = 2;

  typedef struct packed {
    logic                   vld;
    logic [PIPE_BANK_W-1:0] bank;
    logic [PIPE_COL_W-1:0]  col;
  } rd_entry_t;

endpackage

// File: rtl/diram_phy_resp_rd_pipe.sv
// Read latency line plus burst beat engine; presents the storage location of
// the beat to be returned on the next edge.
module diram_phy_resp_rd_pipe
  import diram_phy_resp_pkg::*;
#(
  parameter int READ_LATENCY = 4,
  parameter int BURST_SIZE   = 2,
  parameter int BEAT_W       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  rd_entry_t              push_i,
  output logic                   beat_vld_o,
  output logic [PIPE_BANK_W-1:0] beat_bank_o,
  output logic [PIPE_COL_W-1:0]  beat_col_o,
  output logic [BEAT_W-1:0]      beat_idx_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_SIZE - 1);

  rd_entry_t              pipe_q [READ_LATENCY];
  rd_entry_t              pipe_d [READ_LATENCY];
  rd_entry_t              head;
  logic                   burst_act_q, burst_act_d;
  logic [PIPE_BANK_W-1:0] burst_bank_q, burst_bank_d;
  logic [PIPE_COL_W-1:0]  burst_col_q, burst_col_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;

  assign head = pipe_q[READ_LATENCY-1];

  always_comb begin
    pipe_d[0] = push_i;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // A fresh head always wins, so an overlapping read takes over the burst.
  always_comb begin
    burst_act_d  = burst_act_q;
    burst_bank_d = burst_bank_q;
    burst_col_d  = burst_col_q;
    beat_d       = beat_q;
    beat_vld_o   = 1'b0;
    beat_bank_o  = burst_bank_q;
    beat_col_o   = burst_col_q;
    beat_idx_o   = beat_q;
    if (head.vld) begin
      beat_vld_o   = 1'b1;
      beat_bank_o  = head.bank;
      beat_col_o   = head.col;
      beat_idx_o   = '0;
      burst_act_d  = (BURST_SIZE > 1);
      burst_bank_d = head.bank;
      burst_col_d  = head.col;
      beat_d       = BEAT_W'(1);
    end else if (burst_act_q) begin
      beat_vld_o = 1'b1;
      beat_d     = beat_q + 1'b1;
      if (beat_q == LAST_BEAT) begin
        burst_act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      burst_act_q  <= 1'b0;
      burst_bank_q <= '0;
      burst_col_q  <= '0;
      beat_q       <= '0;
    end else begin
      pipe_q       <= pipe_d;
      burst_act_q  <= burst_act_d;
      burst_bank_q <= burst_bank_d;
      burst_col_q  <= burst_col_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: rtl/diram_phy_resp.sv
// DiRAM PHY-side DFI responder: command decode, burst write capture and fixed-latency read return.
// Define DIRAM_PHY_RESP_ERR_CHK_EN to build the open-row table, spacing checker and sticky error flags.
module diram_phy_resp
  import diram_phy_resp_pkg::*;
#(
  parameter int NUM_BANKS    = DFLT_NUM_BANKS,
  parameter int BANK_W       = $clog2(NUM_BANKS),
  parameter int ADDR_W       = 12,
  parameter int COL_W        = DFLT_COL_W,
  parameter int DATA_W       = 256,
  parameter int BURST_SIZE   = 2,
  parameter int READ_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  input  logic              dfi__phy__cs,
  input  logic              dfi__phy__cmd1,
  input  logic              dfi__phy__cmd0,
  input  logic [BANK_W-1:0] dfi__phy__bank,
  input  logic [ADDR_W-1:0] dfi__phy__addr,
  input  logic [DATA_W-1:0] dfi__phy__data,
  output logic              phy__dfi__valid,
  output logic [DATA_W-1:0] phy__dfi__data,
  output logic [2:0]        phy__dfi__err
);

  localparam int BEAT_W    = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam int MEM_DEPTH = NUM_BANKS * (2 ** COL_W) * BURST_SIZE;
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_SIZE - 1);

  cmd_e              cmd;
  logic [COL_W-1:0]  col;
  logic              cmd_drop, rd_go, wr_go, act_go, pre_go;
  logic              wr_act_q, wr_act_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx, mem_ridx;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  rd_entry_t         rd_push;
  logic              beat_vld;
  logic [BANK_W-1:0] beat_bank;
  logic [COL_W-1:0]  beat_col;
  logic [BEAT_W-1:0] beat_idx;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              unused_bits;

  // Row is deliberately absent: different rows of one bank alias the same words.
  function automatic logic [IDX_W-1:0] mem_idx(input logic [BANK_W-1:0] b,
                                               input logic [COL_W-1:0]  c,
                                               input logic [BEAT_W-1:0] k);
    return IDX_W'((int'(b) * (2 ** COL_W) + int'(c)) * BURST_SIZE + int'(k));
  endfunction

  assign cmd = cmd_e'({dfi__phy__cmd1, dfi__phy__cmd0});
  assign col = dfi__phy__addr[COL_W-1:0];

`ifdef DIRAM_PHY_RESP_ERR_CHK_EN
  logic [NUM_BANKS-1:0]             open_q, open_d;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] row_q, row_d;
  logic [BEAT_W-1:0]                space_q, space_d;
  logic [2:0]                       err_q, err_d;
  logic                             rw_cmd;

  assign rw_cmd   = (cmd == RD) || (cmd == WR);
  assign cmd_drop = dfi__phy__cs && (wr_act_q || (rw_cmd && (space_q != '0)));

  always_comb begin
    open_d  = open_q;
    row_d   = row_q;
    space_d = space_q;
    err_d   = err_q;
    if (space_q != '0) begin
      space_d = space_q - 1'b1;
    end
    if (rd_go || wr_go) begin
      space_d = LAST_BEAT;
      if (!open_q[dfi__phy__bank]) begin
        err_d[ERR_CLOSED] = 1'b1;
      end
    end
    if (act_go) begin
      if (open_q[dfi__phy__bank]) begin
        err_d[ERR_OPEN] = 1'b1;
      end
      open_d[dfi__phy__bank] = 1'b1;
      row_d[dfi__phy__bank]  = dfi__phy__addr;
    end
    if (pre_go) begin
      open_d[dfi__phy__bank] = 1'b0;
    end
    if (cmd_drop) begin
      err_d[ERR_SPACING] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      open_q  <= '0;
      row_q   <= '0;
      space_q <= '0;
      err_q   <= '0;
    end else begin
      open_q  <= open_d;
      row_q   <= row_d;
      space_q <= space_d;
      err_q   <= err_d;
    end
  end

  assign phy__dfi__err = err_q;
  assign unused_bits   = ^row_q;
`else
  assign cmd_drop      = dfi__phy__cs && wr_act_q;
  assign phy__dfi__err = '0;
  assign unused_bits   = ^dfi__phy__addr[ADDR_W-1:COL_W];
`endif

  assign act_go = dfi__phy__cs && !cmd_drop && (cmd == ACT);
  assign rd_go  = dfi__phy__cs && !cmd_drop && (cmd == RD);
  assign wr_go  = dfi__phy__cs && !cmd_drop && (cmd == WR);
  assign pre_go = dfi__phy__cs && !cmd_drop && (cmd == PRE);

  // Beat 0 commits on the command edge; later beats follow on consecutive edges.
  always_comb begin
    wr_act_d  = wr_act_q;
    wr_bank_d = wr_bank_q;
    wr_col_d  = wr_col_q;
    wr_beat_d = wr_beat_q;
    mem_we    = 1'b0;
    mem_widx  = mem_idx(dfi__phy__bank, col, '0);
    if (wr_act_q) begin
      mem_we    = 1'b1;
      mem_widx  = mem_idx(wr_bank_q, wr_col_q, wr_beat_q);
      wr_beat_d = wr_beat_q + 1'b1;
      if (wr_beat_q == LAST_BEAT) begin
        wr_act_d = 1'b0;
      end
    end else if (wr_go) begin
      mem_we    = 1'b1;
      wr_act_d  = (BURST_SIZE > 1);
      wr_bank_d = dfi__phy__bank;
      wr_col_d  = col;
      wr_beat_d = BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= dfi__phy__data;
    end
  end

  assign rd_push = '{vld: rd_go, bank: dfi__phy__bank, col: col};

  diram_phy_resp_rd_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .BURST_SIZE   (BURST_SIZE),
    .BEAT_W       (BEAT_W)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (reset_poweron_n),
    .push_i      (rd_push),
    .beat_vld_o  (beat_vld),
    .beat_bank_o (beat_bank),
    .beat_col_o  (beat_col),
    .beat_idx_o  (beat_idx)
  );

  assign mem_ridx = mem_idx(beat_bank, beat_col, beat_idx);

  always_comb begin
    rd_valid_d = beat_vld;
    rd_data_d  = beat_vld ? mem[mem_ridx] : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      wr_act_q   <= 1'b0;
      wr_bank_q  <= '0;
      wr_col_q   <= '0;
      wr_beat_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_act_q   <= wr_act_d;
      wr_bank_q  <= wr_bank_d;
      wr_col_q   <= wr_col_d;
      wr_beat_q  <= wr_beat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign phy__dfi__valid = rd_valid_q;
  assign phy__dfi__data  = rd_data_q;

endmodule

// File: tb/tb_diram_phy_resp.sv
// Bench for diram_phy_resp: directed bring-up scenarios plus random DFI traffic
// compared every cycle against a cycle-scheduled behavioural model.
module tb_diram_phy_resp;
  import diram_phy_resp_pkg::*;

  localparam int NUM_BANKS    = 8;
  localparam int BANK_W       = 3;
  localparam int ADDR_W       = 12;
  localparam int COL_W        = 4;
  localparam int COLS         = 16;
  localparam int DATA_W       = 256;
  localparam int BURST_SIZE   = 2;
  localparam int READ_LATENCY = 4;

`ifdef DIRAM_PHY_RESP_ERR_CHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic              clk;
  logic              rstN;
  logic              csIn;
  logic [1:0]        cmdIn;
  logic [BANK_W-1:0] bankIn;
  logic [ADDR_W-1:0] addrIn;
  logic [DATA_W-1:0] dataIn;
  logic              phyValid;
  logic [DATA_W-1:0] phyData;
  logic [2:0]        phyErr;

  diram_phy_resp #(
    .NUM_BANKS    (NUM_BANKS),
    .ADDR_W       (ADDR_W),
    .COL_W        (COL_W),
    .DATA_W       (DATA_W),
    .BURST_SIZE   (BURST_SIZE),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk             (clk),
    .reset_poweron_n (rstN),
    .dfi__phy__cs    (csIn),
    .dfi__phy__cmd1  (cmdIn[1]),
    .dfi__phy__cmd0  (cmdIn[0]),
    .dfi__phy__bank  (bankIn),
    .dfi__phy__addr  (addrIn),
    .dfi__phy__data  (dataIn),
    .phy__dfi__valid (phyValid),
    .phy__dfi__data  (phyData),
    .phy__dfi__err   (phyErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int b;
    int c;
    int k;
  } loc_t;

  loc_t              rdSched [int];
  loc_t              wrSched [int];
  logic [DATA_W-1:0] modelMem [NUM_BANKS][COLS][BURST_SIZE];
  bit [NUM_BANKS-1:0] bankOpen;
  logic [2:0]        expErr;
  logic              expValid;
  logic [DATA_W-1:0] expData;
  int                cyc;
  int                lastRw;
  int                totalChecks;
  int                badChecks;

  localparam logic [DATA_W-1:0] PAT_A = {8{32'hAAAA_AAAA}};
  localparam logic [DATA_W-1:0] PAT_B = {8{32'hBBBB_BBBB}};

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] randData();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) begin
      d[i*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  // Reference model: reads and write beats are booked against absolute cycle
  // numbers when their command is accepted, then replayed as the cycles arrive.
  function automatic void modelStep();
    loc_t       l;
    bit         busy;
    bit         drop;
    int         b;
    int         c;
    logic [1:0] op;
    cyc++;
    if (rdSched.exists(cyc)) begin
      l        = rdSched[cyc];
      expValid = 1'b1;
      expData  = modelMem[l.b][l.c][l.k];
      rdSched.delete(cyc);
    end else begin
      expValid = 1'b0;
    end
    busy = wrSched.exists(cyc);
    if (busy) begin
      l = wrSched[cyc];
      modelMem[l.b][l.c][l.k] = dataIn;
      wrSched.delete(cyc);
    end
    if (csIn) begin
      b    = int'(bankIn);
      c    = int'(addrIn) % COLS;
      op   = cmdIn;
      drop = busy;
      if (ERRCHK && (op == RD || op == WR) && (cyc - lastRw < BURST_SIZE)) drop = 1'b1;
      if (drop) begin
        if (ERRCHK) expErr[2] = 1'b1;
      end else if (op == ACT) begin
        if (ERRCHK && bankOpen[b]) expErr[1] = 1'b1;
        bankOpen[b] = 1'b1;
      end else if (op == PRE) begin
        bankOpen[b] = 1'b0;
      end else begin
        if (ERRCHK && !bankOpen[b]) expErr[0] = 1'b1;
        lastRw = cyc;
        for (int k = 0; k < BURST_SIZE; k++) begin
          if (op == RD) rdSched[cyc + READ_LATENCY + k] = '{b, c, k};
          else if (k == 0) modelMem[b][c][0] = dataIn;
          else wrSched[cyc + k] = '{b, c, k};
        end
      end
    end
  endfunction

  task automatic applyStimulus(input bit cs, input logic [1:0] cmd, input int bank,
                               input int addr, input logic [DATA_W-1:0] data);
    csIn   = cs;
    cmdIn  = cmd;
    bankIn = BANK_W'(bank);
    addrIn = ADDR_W'(addr);
    dataIn = data;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("valid", DATA_W'(phyValid), DATA_W'(expValid));
    checkOutput("data", phyData, expData);
    checkOutput("err", DATA_W'(phyErr), DATA_W'(expErr));
  endtask

  task automatic idleCycles(input int n, input logic [DATA_W-1:0] data);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, ACT, 0, 0, data);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    csIn = 1'b0;
    rdSched.delete();
    wrSched.delete();
    bankOpen = '0;
    expErr   = '0;
    expValid = 1'b0;
    expData  = '0;
    lastRw   = -1000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", DATA_W'(phyValid), '0);
    checkOutput("rst_data", phyData, '0);
    checkOutput("rst_err", DATA_W'(phyErr), '0);
    rstN = 1'b1;
  endtask

  int beats;

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    cyc         = 0;
    rstN        = 1'b0;
    csIn        = 1'b0;
    cmdIn       = '0;
    bankIn      = '0;
    addrIn      = '0;
    dataIn      = '0;
    doReset();

    // Give every storage word a known value so later reads are fully predictable.
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < COLS; c++) begin
        applyStimulus(1'b1, WR, b, c, randData());
        applyStimulus(1'b0, ACT, 0, 0, randData());
      end
    end
    doReset();

    // Scenario 1: activate, write two beats, read back after latency 4.
    applyStimulus(1'b1, ACT, 3, 12'h155, '0);
    applyStimulus(1'b1, WR, 3, 5, PAT_A);
    applyStimulus(1'b0, ACT, 0, 0, PAT_B);
    applyStimulus(1'b1, RD, 3, 5, '0);
    idleCycles(3, '0);
    checkOutput("s1_pre_valid", DATA_W'(phyValid), '0);
    idleCycles(1, '0);
    checkOutput("s1_beat0_valid", DATA_W'(phyValid), DATA_W'(1));
    checkOutput("s1_beat0_data", phyData, PAT_A);
    idleCycles(1, '0);
    checkOutput("s1_beat1_valid", DATA_W'(phyValid), DATA_W'(1));
    checkOutput("s1_beat1_data", phyData, PAT_B);
    idleCycles(1, '0);
    checkOutput("s1_post_valid", DATA_W'(phyValid), '0);
    checkOutput("s1_hold_data", phyData, PAT_B);
    checkOutput("s1_err", DATA_W'(phyErr), '0);

    // Scenario 2: reads two cycles apart give four gap-free beats.
    applyStimulus(1'b1, RD, 0, 1, '0);
    applyStimulus(1'b0, ACT, 0, 0, '0);
    applyStimulus(1'b1, RD, 0, 2, '0);
    for (int e = 3; e <= 8; e++) begin
      applyStimulus(1'b0, ACT, 0, 0, '0);
      checkOutput("s2_valid", DATA_W'(phyValid), DATA_W'(e >= 4 && e <= 7));
    end

    // Scenario 3: read from a never-activated bank.
    doReset();
    applyStimulus(1'b1, RD, 6, 0, '0);
    idleCycles(4, '0);
    checkOutput("s3_valid", DATA_W'(phyValid), DATA_W'(1));
    idleCycles(2, '0);
    checkOutput("s3_err", DATA_W'(phyErr), DATA_W'(ERRCHK ? 3'b001 : 3'b000));

    // Scenario 4: double activate, then reads one cycle apart.
    doReset();
    applyStimulus(1'b1, ACT, 2, 7, '0);
    applyStimulus(1'b0, ACT, 0, 0, '0);
    applyStimulus(1'b1, ACT, 2, 9, '0);
    checkOutput("s4_act_err", DATA_W'(phyErr), DATA_W'(ERRCHK ? 3'b010 : 3'b000));
    beats = 0;
    applyStimulus(1'b1, RD, 2, 4, '0);
    applyStimulus(1'b1, RD, 2, 5, '0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, ACT, 0, 0, '0);
      beats += int'(phyValid);
    end
    checkOutput("s4_beats", DATA_W'(beats), DATA_W'(ERRCHK ? 2 : 3));
    checkOutput("s4_err", DATA_W'(phyErr), DATA_W'(ERRCHK ? 3'b110 : 3'b000));

    // Scenario 5: reset lands on the first read beat.
    applyStimulus(1'b1, ACT, 1, 3, '0);
    applyStimulus(1'b1, RD, 1, 3, '0);
    idleCycles(4, '0);
    checkOutput("s5_first_beat", DATA_W'(phyValid), DATA_W'(1));
    rstN = 1'b0;
    #1;
    checkOutput("s5_async_valid", DATA_W'(phyValid), '0);
    doReset();
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ACT, 0, 0, '0);
      beats += int'(phyValid);
    end
    checkOutput("s5_no_stale", DATA_W'(beats), '0);
    applyStimulus(1'b1, RD, 5, 3, '0);
    idleCycles(6, '0);
    checkOutput("s5_err", DATA_W'(phyErr), DATA_W'(ERRCHK ? 3'b001 : 3'b000));

    // Random traffic, including illegal spacing and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      applyStimulus(($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, NUM_BANKS - 1)), int'($urandom_range(0, 4095)),
                    randData());
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
